fir_seq_ctrl: RTL and testbench

- Sequencer for the FIR-plus-FIFO datapath.
- Loads the TAPS coefficient bank from a valid/ready stream, then streams a programmed number of samples from the input FIFO through the FIR into the output FIFO.
- Issues a FIR input only when the output FIFO has guaranteed room for its result (credit-based), so no result is ever dropped.
- Sits between the bus-side register block (start, load, abort, length) and the FIR/FIFO datapath.

---
 rtl/fir_seq_ctrl_if.sv | 57 +++++
 rtl/fir_seq_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_fir_seq_ctrl.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_seq_ctrl_if.sv
// Bus-side and datapath-side handshake bundle for the FIR sequencer.
// The slave modport is the sequencer view; the master modport is the
// view of whatever drives the commands and models the FIFOs/FIR.
interface fir_seq_ctrl_if #(
  parameter int TAPS      = 20,
  parameter int BIT_PREC  = 8,
  parameter int OUT_DEPTH = 16,
  parameter int CNT_W     = 16
) ();
  localparam int ADDR_W = $clog2(TAPS);
  localparam int FREE_W = $clog2(OUT_DEPTH + 1);

  // command side
  logic                load_start;
  logic                run_start;
  logic                abort;
  logic [CNT_W-1:0]    num_samples;

  // coefficient stream and bank write port
  logic                coef_valid;
  logic [BIT_PREC-1:0] coef_data;
  logic                coef_ready;
  logic                coef_we;
  logic [ADDR_W-1:0]   coef_addr;
  logic [BIT_PREC-1:0] coef_wdata;

  // FIFO / FIR control
  logic                in_fifo_empty;
  logic                in_fifo_rd;
  logic                fir_in_valid;
  logic [FREE_W-1:0]   out_fifo_free;
  logic                out_fifo_wr;

  // status
  logic                busy;
  logic                coef_loaded;
  logic                done;
  logic [CNT_W-1:0]    sample_cnt;

  modport master (
    output load_start, run_start, abort, num_samples,
    output coef_valid, coef_data,
    output in_fifo_empty, out_fifo_free,
    input  coef_ready, coef_we, coef_addr, coef_wdata,
    input  in_fifo_rd, fir_in_valid, out_fifo_wr,
    input  busy, coef_loaded, done, sample_cnt
  );

  modport slave (
    input  load_start, run_start, abort, num_samples,
    input  coef_valid, coef_data,
    input  in_fifo_empty, out_fifo_free,
    output coef_ready, coef_we, coef_addr, coef_wdata,
    output in_fifo_rd, fir_in_valid, out_fifo_wr,
    output busy, coef_loaded, done, sample_cnt
  );
endinterface

// File: rtl/fir_seq_ctrl.sv
// Sequencer for the FIR-plus-FIFO datapath. Loads the coefficient bank
// from a valid/ready stream, then streams a programmed number of samples
// from the input FIFO through the FIR into the output FIFO. A pop is only
// issued when the output FIFO has a committed free slot for every result
// still in flight, so results can never be dropped.
module fir_seq_ctrl #(
  parameter int TAPS      = 20,
  parameter int BIT_PREC  = 8,
  parameter int FIR_LAT   = 2,
  parameter int OUT_DEPTH = 16,
  parameter int CNT_W     = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  fir_seq_ctrl_if.slave  bus
);
  localparam int ADDR_W = $clog2(TAPS);
  localparam int FREE_W = $clog2(OUT_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t              state;
  state_t              state_nxt;

  // coefficient load bookkeeping
  logic [ADDR_W-1:0]   coef_idx;
  logic                coef_loaded_r;
  logic                coef_we_r;
  logic [ADDR_W-1:0]   coef_addr_r;
  logic [BIT_PREC-1:0] coef_wdata_r;

  // run bookkeeping
  logic [CNT_W-1:0]    run_len;
  logic [CNT_W-1:0]    issued;
  logic [CNT_W-1:0]    sample_cnt_r;
  logic [FREE_W-1:0]   inflight;

  // valid delay line: vld_p[0] is the FIR input strobe (pop + 1 cycle),
  // vld_p[FIR_LAT] is the matching output FIFO push.
  logic [FIR_LAT:0]    vld_p;

  // combinational decodes
  logic                coef_ready_c;
  logic                pop_c;
  logic                done_c;
  logic                coef_hs;
  logic                last_coef;
  logic                accept_load;
  logic                accept_run;
  logic                push;

  assign coef_hs     = coef_ready_c && bus.coef_valid;
  assign last_coef   = coef_hs && (coef_idx == ADDR_W'(TAPS - 1));
  assign accept_load = (state == IDLE) && !bus.abort && bus.load_start;
  assign accept_run  = (state == IDLE) && !bus.abort && !bus.load_start &&
                       bus.run_start && coef_loaded_r;
  assign push        = vld_p[FIR_LAT];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; abort overrides every state and every start pulse
  always_comb begin
    state_nxt = state;
    if (bus.abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (bus.load_start) begin
            state_nxt = LOAD;
          end else if (bus.run_start && coef_loaded_r) begin
            state_nxt = RUN;
          end
        end
        LOAD: begin
          if (last_coef) begin
            state_nxt = IDLE;
          end
        end
        RUN: begin
          if (issued == run_len) begin
            state_nxt = DRAIN;
          end
        end
        DRAIN: begin
          if (inflight == '0) begin
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Per-state outputs: stream ready, credit-gated pop, end-of-run pulse.
  // All of them are masked by abort so nothing is accepted in that cycle.
  always_comb begin
    coef_ready_c = 1'b0;
    pop_c        = 1'b0;
    done_c       = 1'b0;
    case (state)
      LOAD:  coef_ready_c = !bus.abort;
      RUN:   pop_c        = !bus.abort && !bus.in_fifo_empty &&
                            (issued < run_len) &&
                            (inflight < bus.out_fifo_free);
      DRAIN: done_c       = !bus.abort && (inflight == '0);
      default: ;
    endcase
  end

  // Coefficient index, bank write port and loaded flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coef_idx      <= '0;
      coef_loaded_r <= 1'b0;
      coef_we_r     <= 1'b0;
      coef_addr_r   <= '0;
      coef_wdata_r  <= '0;
    end else begin
      coef_we_r <= coef_hs;
      if (accept_load) begin
        coef_idx      <= '0;
        coef_loaded_r <= 1'b0;
      end else if (coef_hs) begin
        coef_addr_r  <= coef_idx;
        coef_wdata_r <= bus.coef_data;
        coef_idx     <= coef_idx + ADDR_W'(1);
        if (last_coef) begin
          coef_loaded_r <= 1'b1;
        end
      end
    end
  end

  // Run length latch, issue counter and pushed-result counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_len      <= '0;
      issued       <= '0;
      sample_cnt_r <= '0;
    end else if (accept_run) begin
      run_len      <= bus.num_samples;
      issued       <= '0;
      sample_cnt_r <= '0;
    end else begin
      if (pop_c) begin
        issued <= issued + CNT_W'(1);
      end
      if (push) begin
        sample_cnt_r <= sample_cnt_r + CNT_W'(1);
      end
    end
  end

  // Outstanding pops not yet pushed; abort forgets them with the delay line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= '0;
    end else if (bus.abort) begin
      inflight <= '0;
    end else begin
      case ({pop_c, push})
        2'b10:   inflight <= inflight + FREE_W'(1);
        2'b01:   inflight <= inflight - FREE_W'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  // Pipeline stage boundary: pop -> FIR input strobe -> output FIFO push
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p <= '0;
    end else if (bus.abort) begin
      vld_p <= '0;
    end else begin
      vld_p <= {vld_p[FIR_LAT-1:0], pop_c};
    end
  end

  assign bus.coef_ready   = coef_ready_c;
  assign bus.coef_we      = coef_we_r;
  assign bus.coef_addr    = coef_addr_r;
  assign bus.coef_wdata   = coef_wdata_r;
  assign bus.in_fifo_rd   = pop_c;
  assign bus.fir_in_valid = vld_p[0];
  assign bus.out_fifo_wr  = push;
  assign bus.busy         = (state != IDLE);
  assign bus.coef_loaded  = coef_loaded_r;
  assign bus.done         = done_c;
  assign bus.sample_cnt   = sample_cnt_r;

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Bench for fir_seq_ctrl: directed scenarios plus a timestamp-based
// behavioural model that is compared against the outputs every cycle.
module tb_fir_seq_ctrl;
  localparam int TAPS      = 20;
  localparam int BIT_PREC  = 8;
  localparam int FIR_LAT   = 2;
  localparam int OUT_DEPTH = 16;
  localparam int CNT_W     = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  fir_seq_ctrl_if #(.TAPS(TAPS), .BIT_PREC(BIT_PREC), .OUT_DEPTH(OUT_DEPTH),
                    .CNT_W(CNT_W)) bus ();

  fir_seq_ctrl #(.TAPS(TAPS), .BIT_PREC(BIT_PREC), .FIR_LAT(FIR_LAT),
                 .OUT_DEPTH(OUT_DEPTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // behavioural model: mode 0 idle, 1 load, 2 run, 3 drain
  int m_mode, m_idx, m_len, m_issued, m_cnt;
  bit m_loaded;
  int pq[$];            // cycle stamps of pops whose result is still due
  bit w_pend;
  int w_addr, w_data;

  // observed-event logs
  typedef struct { int c; int a; int d; } we_t;
  we_t we_log[$];
  int  pop_log[$];
  int  wr_log[$];
  int  done_log[$];
  int  act_infl, max_infl;

  int in_avail;
  bit pop_now;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_idx = 0; m_len = 0; m_issued = 0; m_cnt = 0;
    m_loaded = 0; w_pend = 0; w_addr = 0; w_data = 0;
    pq.delete();
  endtask

  // Per-cycle compare and model advance, evaluated mid-cycle
  task automatic cycle_check();
    bit e_rdy, e_rd, e_fv, e_wr, e_done, hs;
    int iss0;
    if (!rst_n) begin
      model_reset();
      chk("rst_busy", bus.busy, 0);
      chk("rst_coef_ready", bus.coef_ready, 0);
      chk("rst_in_fifo_rd", bus.in_fifo_rd, 0);
      chk("rst_fir_in_valid", bus.fir_in_valid, 0);
      chk("rst_out_fifo_wr", bus.out_fifo_wr, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_coef_we", bus.coef_we, 0);
      chk("rst_coef_addr", bus.coef_addr, 0);
      chk("rst_coef_wdata", bus.coef_wdata, 0);
      chk("rst_coef_loaded", bus.coef_loaded, 0);
      chk("rst_sample_cnt", bus.sample_cnt, 0);
      pop_now = 0;
      cyc++;
      return;
    end
    e_rdy  = (m_mode == 1) && !bus.abort;
    e_rd   = (m_mode == 2) && !bus.abort && !bus.in_fifo_empty &&
             (m_issued < m_len) && (pq.size() < int'(bus.out_fifo_free));
    e_fv   = 0;
    foreach (pq[i]) if (pq[i] == cyc - 1) e_fv = 1;
    e_wr   = (pq.size() > 0) && (pq[0] == cyc - 1 - FIR_LAT);
    e_done = (m_mode == 3) && (pq.size() == 0) && !bus.abort;

    chk("busy", bus.busy, (m_mode != 0));
    chk("coef_ready", bus.coef_ready, e_rdy);
    chk("in_fifo_rd", bus.in_fifo_rd, e_rd);
    chk("fir_in_valid", bus.fir_in_valid, e_fv);
    chk("out_fifo_wr", bus.out_fifo_wr, e_wr);
    chk("done", bus.done, e_done);
    chk("coef_we", bus.coef_we, w_pend);
    chk("coef_addr", bus.coef_addr, w_addr);
    chk("coef_wdata", bus.coef_wdata, w_data);
    chk("coef_loaded", bus.coef_loaded, m_loaded);
    chk("sample_cnt", bus.sample_cnt, m_cnt);

    if (bus.in_fifo_rd)  pop_log.push_back(cyc);
    if (bus.out_fifo_wr) wr_log.push_back(cyc);
    if (bus.done)        done_log.push_back(cyc);
    if (bus.coef_we)     we_log.push_back('{c: cyc, a: int'(bus.coef_addr), d: int'(bus.coef_wdata)});
    act_infl = act_infl + int'(bus.in_fifo_rd) - int'(bus.out_fifo_wr);
    if (act_infl > max_infl) max_infl = act_infl;
    pop_now = bus.in_fifo_rd;

    // advance the model to the next cycle
    hs   = e_rdy && bus.coef_valid;
    iss0 = m_issued;
    w_pend = hs;
    if (hs) begin
      w_addr = m_idx;
      w_data = int'(bus.coef_data);
    end
    if (e_wr) begin
      void'(pq.pop_front());
      m_cnt++;
    end
    if (e_rd) begin
      pq.push_back(cyc);
      m_issued++;
    end
    if (bus.abort) begin
      m_mode = 0;
      pq.delete();
    end else begin
      case (m_mode)
        0: begin
          if (bus.load_start) begin
            m_mode = 1; m_loaded = 0; m_idx = 0;
          end else if (bus.run_start && m_loaded) begin
            m_mode = 2; m_len = int'(bus.num_samples); m_issued = 0; m_cnt = 0;
          end
        end
        1: if (hs) begin
          if (m_idx == TAPS - 1) begin
            m_mode = 0; m_loaded = 1;
          end
          m_idx++;
        end
        2: if (iss0 == m_len) m_mode = 3;
        default: if (e_done) m_mode = 0;
      endcase
    end
    cyc++;
  endtask

  task automatic set_avail(input int n);
    in_avail = n;
    bus.in_fifo_empty = (n == 0);
  endtask

  // one clock: compare mid-cycle, then return just after the next edge
  task automatic tick();
    @(negedge clk);
    cycle_check();
    @(posedge clk);
    #1;
    if (pop_now && in_avail > 0) in_avail--;
    bus.in_fifo_empty = (in_avail == 0);
  endtask

  task automatic wait_done(input int budget, input string name);
    int d0 = done_log.size();
    int k  = 0;
    while (done_log.size() == d0 && k < budget) begin
      tick();
      k++;
    end
    chk(name, (done_log.size() > d0), 1);
  endtask

  initial begin
    int s, p0, w0, d0, k, wc;
    bus.load_start = 0; bus.run_start = 0; bus.abort = 0; bus.num_samples = '0;
    bus.coef_valid = 0; bus.coef_data = '0; bus.out_fifo_free = 5'd16;
    set_avail(0);
    act_infl = 0; max_infl = 0; pop_now = 0;
    model_reset();

    // reset state
    repeat (3) tick();
    rst_n = 1;
    tick();

    // run_start without coefficients is ignored
    bus.num_samples = 16'd5; bus.run_start = 1;
    tick();
    bus.run_start = 0;
    tick();
    chk("guard_busy", bus.busy, 0);
    chk("guard_no_pop", pop_log.size(), 0);

    // coefficient load 1..20 without stalls
    s = cyc;
    bus.load_start = 1;
    tick();
    bus.load_start = 0;
    bus.coef_valid = 1;
    for (int i = 1; i <= TAPS; i++) begin
      bus.coef_data = BIT_PREC'(i);
      tick();
    end
    bus.coef_valid = 0;
    repeat (2) tick();
    chk("load_we_count", we_log.size(), TAPS);
    if (we_log.size() >= TAPS) begin
      chk("load_first_we_cycle", we_log[0].c, s + 2);
      for (int i = 0; i < TAPS; i++) begin
        chk("load_addr", we_log[i].a, i);
        chk("load_data", we_log[i].d, i + 1);
        chk("load_consecutive", we_log[i].c, we_log[0].c + i);
      end
    end
    chk("load_coef_loaded", bus.coef_loaded, 1);
    chk("load_idle", bus.busy, 0);

    // back-pressured run: 8 samples, output FIFO reports 2 free
    bus.out_fifo_free = 5'd2;
    set_avail(8);
    act_infl = 0; max_infl = 0;
    p0 = pop_log.size(); w0 = wr_log.size(); d0 = done_log.size();
    bus.num_samples = 16'd8;
    s = cyc;
    bus.run_start = 1;
    tick();
    bus.run_start = 0;
    wait_done(80, "bp_done_seen");
    repeat (2) tick();
    chk("bp_pops", pop_log.size() - p0, 8);
    chk("bp_pushes", wr_log.size() - w0, 8);
    if (pop_log.size() - p0 == 8 && wr_log.size() - w0 == 8) begin
      chk("bp_first_pop", pop_log[p0], s + 1);
      for (int i = 0; i < 8; i++) chk("bp_push_latency", wr_log[w0 + i] - pop_log[p0 + i], 3);
    end
    chk("bp_max_inflight", max_infl, 2);
    chk("bp_single_done", done_log.size() - d0, 1);
    if (done_log.size() > d0) chk("bp_done_cycle", done_log[d0], s + 18);
    chk("bp_sample_cnt", bus.sample_cnt, 8);

    // starved input: empty for 10 cycles, then 4 words arrive
    bus.out_fifo_free = 5'd16;
    set_avail(0);
    p0 = pop_log.size(); w0 = wr_log.size(); d0 = done_log.size();
    bus.num_samples = 16'd4;
    bus.run_start = 1;
    tick();
    bus.run_start = 0;
    repeat (10) tick();
    chk("starve_no_pop", pop_log.size() - p0, 0);
    chk("starve_busy", bus.busy, 1);
    set_avail(4);
    wait_done(40, "starve_done_seen");
    repeat (3) tick();
    chk("starve_pops", pop_log.size() - p0, 4);
    chk("starve_pushes", wr_log.size() - w0, 4);
    chk("starve_single_done", done_log.size() - d0, 1);
    chk("starve_sample_cnt", bus.sample_cnt, 4);

    // zero-length run
    set_avail(3);
    p0 = pop_log.size(); d0 = done_log.size();
    bus.num_samples = 16'd0;
    s = cyc;
    bus.run_start = 1;
    tick();
    bus.run_start = 0;
    wait_done(10, "zero_done_seen");
    if (done_log.size() > d0) chk("zero_done_cycle", done_log[d0], s + 2);
    chk("zero_no_pop", pop_log.size() - p0, 0);
    chk("zero_sample_cnt", bus.sample_cnt, 0);

    // abort one cycle after the third pop of a 10-sample run
    set_avail(10);
    p0 = pop_log.size(); w0 = wr_log.size(); d0 = done_log.size();
    bus.num_samples = 16'd10;
    bus.run_start = 1;
    tick();
    bus.run_start = 0;
    k = 0;
    while (pop_log.size() < p0 + 3 && k < 20) begin
      tick();
      k++;
    end
    chk("abort_three_pops", pop_log.size() - p0, 3);
    bus.abort = 1;
    tick();
    bus.abort = 0;
    chk("abort_idle", bus.busy, 0);
    wc = wr_log.size();
    repeat (8) tick();
    chk("abort_no_more_push", wr_log.size(), wc);
    chk("abort_pushes", wr_log.size() - w0, 1);
    chk("abort_pops", pop_log.size() - p0, 3);
    chk("abort_no_done", done_log.size() - d0, 0);
    chk("abort_keeps_loaded", bus.coef_loaded, 1);
    chk("abort_sample_cnt", bus.sample_cnt, 1);

    // abort during a coefficient load leaves the bank unloaded
    bus.load_start = 1;
    tick();
    bus.load_start = 0;
    bus.coef_valid = 1;
    for (int i = 0; i < 3; i++) begin
      bus.coef_data = BIT_PREC'(30 + i);
      tick();
    end
    bus.abort = 1;
    tick();
    bus.abort = 0;
    bus.coef_valid = 0;
    chk("load_abort_idle", bus.busy, 0);
    chk("load_abort_unloaded", bus.coef_loaded, 0);
    tick();

    // asynchronous reset in the middle of a load
    bus.load_start = 1;
    tick();
    bus.load_start = 0;
    bus.coef_valid = 1;
    for (int i = 1; i <= 5; i++) begin
      bus.coef_data = BIT_PREC'(40 + i);
      tick();
    end
    #2 rst_n = 0;
    #1;
    chk("async_busy", bus.busy, 0);
    chk("async_coef_ready", bus.coef_ready, 0);
    chk("async_coef_we", bus.coef_we, 0);
    chk("async_coef_addr", bus.coef_addr, 0);
    chk("async_coef_wdata", bus.coef_wdata, 0);
    chk("async_coef_loaded", bus.coef_loaded, 0);
    chk("async_sample_cnt", bus.sample_cnt, 0);
    bus.coef_valid = 0;
    repeat (2) tick();
    rst_n = 1;
    tick();
    bus.num_samples = 16'd3;
    bus.run_start = 1;
    tick();
    bus.run_start = 0;
    tick();
    chk("post_reset_run_ignored", bus.busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
